// File: rtl/asteroid_pkg.sv
// Shared types for the asteroid frame sequencer.
// Edge behaviour is selected by ASTEROID_WRAP_EN (wrap) or left undefined (bounce).
package asteroid_pkg;

  localparam logic [8:0] SCR_W = 9'd160;
  localparam logic [7:0] SCR_H = 8'd120;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'b00,
    DIR_UP    = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef struct packed {
    logic       active;
    logic [7:0] x;
    logic [6:0] y;
    dir_t       dir;
    logic [1:0] speed;
  } ast_rec_t;

  typedef struct packed {
    logic       we;
    logic [7:0] x;
    logic [6:0] y;
  } pix_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ERASE,
    S_MOVE,
    S_DRAW,
    S_NEXT,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/asteroid_scheduler_if.sv
// Pixel-write port between the asteroid sequencer and the VGA plotter.
interface asteroid_scheduler_if;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       pix_we;
  logic       pix_ready;

  modport master (
    output pix_x, pix_y, pix_colour, pix_we,
    input  pix_ready
  );

  modport slave (
    input  pix_x, pix_y, pix_colour, pix_we,
    output pix_ready
  );
endinterface

// File: rtl/asteroid_step.sv
// One-frame position step for a single asteroid record.
// ASTEROID_WRAP_EN selects wrap-around edges; otherwise clamp and reverse.
module asteroid_step
  import asteroid_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  ast_rec_t rec_in,
  output ast_rec_t rec_out
);

  localparam logic [8:0] XMAX = SCR_W - 9'(SIZE);
  localparam logic [7:0] YMAX = SCR_H - 8'(SIZE);

  logic [8:0] xs, xd, xa;
  logic [7:0] ys, yd, ya;

  always_comb begin
    rec_out = rec_in;
    xs = {1'b0, rec_in.x} + {7'd0, rec_in.speed};
    xd = {1'b0, rec_in.x} - {7'd0, rec_in.speed};
    ys = {1'b0, rec_in.y} + {6'd0, rec_in.speed};
    yd = {1'b0, rec_in.y} - {6'd0, rec_in.speed};
    xa = '0;
    ya = '0;
`ifdef ASTEROID_WRAP_EN
    // a negative difference shows up as the top bit set
    unique case (rec_in.dir)
      DIR_RIGHT: begin
        xa = (xs >= SCR_W) ? xs - SCR_W : xs;
        rec_out.x = xa[7:0];
      end
      DIR_LEFT: begin
        xa = xd[8] ? xd + SCR_W : xd;
        rec_out.x = xa[7:0];
      end
      DIR_DOWN: begin
        ya = (ys >= SCR_H) ? ys - SCR_H : ys;
        rec_out.y = ya[6:0];
      end
      DIR_UP: begin
        ya = yd[7] ? yd + SCR_H : yd;
        rec_out.y = ya[6:0];
      end
    endcase
`else
    unique case (rec_in.dir)
      DIR_RIGHT, DIR_LEFT: begin
        xa = (rec_in.dir == DIR_RIGHT) ? xs : xd;
        if (rec_in.dir == DIR_LEFT && xd[8]) begin
          xa = '0;
          rec_out.dir = dir_t'(rec_in.dir ^ 2'b01);
        end else if (xa > XMAX) begin
          xa = XMAX;
          rec_out.dir = dir_t'(rec_in.dir ^ 2'b01);
        end
        rec_out.x = xa[7:0];
      end
      DIR_DOWN, DIR_UP: begin
        ya = (rec_in.dir == DIR_DOWN) ? ys : yd;
        if (rec_in.dir == DIR_UP && yd[7]) begin
          ya = '0;
          rec_out.dir = dir_t'(rec_in.dir ^ 2'b01);
        end else if (ya > YMAX) begin
          ya = YMAX;
          rec_out.dir = dir_t'(rec_in.dir ^ 2'b01);
        end
        rec_out.y = ya[6:0];
      end
    endcase
`endif
  end

endmodule

// File: rtl/asteroid_scheduler.sv
// Per-frame erase/move/redraw sequencer over the asteroid slot table.
// Edge mode: ASTEROID_WRAP_EN (inside asteroid_step).
module asteroid_scheduler
  import asteroid_pkg::*;
#(
  parameter int          NUM_AST   = 8,
  parameter int          SIZE      = 4,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  localparam int         IW        = $clog2(NUM_AST)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [7:0]    cfg_x,
  input  logic [6:0]    cfg_y,
  input  logic [1:0]    cfg_dir,
  input  logic [1:0]    cfg_speed,
  input  logic          cfg_active,
  asteroid_scheduler_if.master pix,
  output logic          busy,
  output logic          frame_done
);

  localparam int PW = $clog2(SIZE * SIZE);
  localparam logic [PW-1:0] LAST_PIX = PW'(SIZE * SIZE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_AST - 1);

  sched_state_t  state;
  ast_rec_t      tab [NUM_AST];
  ast_rec_t      cur, nxt, cfg_rec;
  logic [IW-1:0] idx;
  logic [PW-1:0] cnt;
  logic          hit, cfg_hit, adv;
  pix_t          px;
  logic [2:0]    colour;

  function automatic pix_t pix_at(ast_rec_t r, logic [PW-1:0] p);
    pix_t o;
    logic [8:0] ax;
    logic [7:0] ay;
    ax = {1'b0, r.x} + 9'(p % PW'(SIZE));
    ay = {1'b0, r.y} + 8'(p / PW'(SIZE));
    o.we = (ax < SCR_W) && (ay < SCR_H);
    o.x = ax[7:0];
    o.y = ay[6:0];
    return o;
  endfunction

  asteroid_step #(.SIZE(SIZE)) u_step (
    .rec_in (cur),
    .rec_out(nxt)
  );

  assign cfg_rec = '{active: cfg_active, x: cfg_x, y: cfg_y,
                     dir: dir_t'(cfg_dir), speed: cfg_speed};
  assign cfg_hit = cfg_we && (cfg_idx == idx);
  // off-screen pixels (we low) advance without waiting for the plotter
  assign adv = !px.we || pix.pix_ready;

  assign pix.pix_x      = px.x;
  assign pix.pix_y      = px.y;
  assign pix.pix_we     = px.we;
  assign pix.pix_colour = colour;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      cur        <= '0;
      hit        <= 1'b0;
      px         <= '0;
      colour     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < NUM_AST; i++) tab[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (frame_tick) begin
          state <= S_LOAD;
          idx   <= '0;
          busy  <= 1'b1;
        end
        S_LOAD: begin
          cur <= tab[idx];
          hit <= cfg_hit;
          cnt <= '0;
          if (tab[idx].active) begin
            px     <= pix_at(tab[idx], '0);
            colour <= BG_COLOUR;
            state  <= S_ERASE;
          end else begin
            state <= S_NEXT;
          end
        end
        S_ERASE: begin
          hit <= hit | cfg_hit;
          if (adv) begin
            if (cnt == LAST_PIX) begin
              px.we <= 1'b0;
              state <= S_MOVE;
            end else begin
              cnt <= PW'(cnt + 1'b1);
              px  <= pix_at(cur, PW'(cnt + 1'b1));
            end
          end
        end
        S_MOVE: begin
          // a cfg write to this slot earlier in its pass takes priority
          if (!hit) tab[idx] <= nxt;
          cur    <= nxt;
          cnt    <= '0;
          px     <= pix_at(nxt, '0);
          colour <= FG_COLOUR;
          state  <= S_DRAW;
        end
        S_DRAW: if (adv) begin
          if (cnt == LAST_PIX) begin
            px.we <= 1'b0;
            state <= S_NEXT;
          end else begin
            cnt <= PW'(cnt + 1'b1);
            px  <= pix_at(cur, PW'(cnt + 1'b1));
          end
        end
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            idx   <= IW'(idx + 1'b1);
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (cfg_we) tab[cfg_idx] <= cfg_rec;
    end
  end

endmodule

// File: tb/tb_asteroid_scheduler.sv
// Randomised bench for asteroid_scheduler against a per-frame pixel-list model.
module tb_asteroid_scheduler;

  typedef struct {
    bit act;
    int x, y, d, s;
  } mrec_t;

  logic       clk = 0;
  logic       reset = 1;
  logic       frame_tick = 0;
  logic       cfg_we = 0;
  logic [2:0] cfg_idx = 0;
  logic [7:0] cfg_x = 0;
  logic [6:0] cfg_y = 0;
  logic [1:0] cfg_dir = 0;
  logic [1:0] cfg_speed = 0;
  logic       cfg_active = 0;
  logic       busy, frame_done;
  bit         rnd_ready = 0;

  asteroid_scheduler_if pif ();

  asteroid_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_x     (cfg_x),
    .cfg_y     (cfg_y),
    .cfg_dir   (cfg_dir),
    .cfg_speed (cfg_speed),
    .cfg_active(cfg_active),
    .pix       (pif),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  mrec_t mt [8];
  logic [17:0] exp_q [$];
  logic [17:0] act_q [$];
  bit          hold_pend = 0;
  logic [17:0] hold_val;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    pif.pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset && hold_pend)
      chk("hold", {pif.pix_we, pif.pix_x, pif.pix_y, pif.pix_colour},
          {1'b1, hold_val});
    hold_pend = !reset && pif.pix_we && !pif.pix_ready;
    hold_val  = {pif.pix_x, pif.pix_y, pif.pix_colour};
    if (!reset && pif.pix_we && pif.pix_ready)
      act_q.push_back({pif.pix_x, pif.pix_y, pif.pix_colour});
  end

  function automatic mrec_t mk(bit a, int x, int y, int d, int s);
    mrec_t r;
    r.act = a; r.x = x; r.y = y; r.d = d; r.s = s;
    return r;
  endfunction

  function automatic mrec_t mstep(mrec_t r);
    mrec_t o = r;
    int v;
    int dv;
    bit horiz = (r.d >= 2);
    dv = (r.d == 3 || r.d == 0) ? r.s : -r.s;
    v  = horiz ? r.x + dv : r.y + dv;
`ifdef ASTEROID_WRAP_EN
    if (horiz) o.x = (v + 160) % 160;
    else       o.y = (v + 120) % 120;
`else
    if (v < 0) begin
      v = 0; o.d = r.d ^ 1;
    end else if (v > (horiz ? 156 : 116)) begin
      v = horiz ? 156 : 116; o.d = r.d ^ 1;
    end
    if (horiz) o.x = v;
    else       o.y = v;
`endif
    return o;
  endfunction

  function automatic void emit(mrec_t r, logic [2:0] c);
    for (int p = 0; p < 16; p++) begin
      int px = r.x + p % 4;
      int py = r.y + p / 4;
      if (px < 160 && py < 120)
        exp_q.push_back({8'(px), 7'(py), c});
    end
  endfunction

  function automatic int model_pass();
    int cyc = 1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (mt[i].act) begin
        emit(mt[i], 3'b000);
        mt[i] = mstep(mt[i]);
        emit(mt[i], 3'b111);
        cyc += 35;
      end else begin
        cyc += 2;
      end
    end
    return cyc;
  endfunction

  task automatic drive_cfg(input int i, input mrec_t r);
    cfg_we = 1; cfg_idx = 3'(i);
    cfg_x = 8'(r.x); cfg_y = 7'(r.y);
    cfg_dir = 2'(r.d); cfg_speed = 2'(r.s);
    cfg_active = r.act;
  endtask

  task automatic cfg_write(input int i, input mrec_t r);
    @(posedge clk); #1;
    drive_cfg(i, r);
    @(posedge clk); #1;
    cfg_we = 0;
    mt[i] = r;
  endtask

  task automatic run_frame(input string tag, input bit timed,
                           input int mid_at, input mrec_t mid_rec,
                           input bit extra_tick);
    int  exp_n, n, nq;
    bit  got, mid_done;
    exp_n = model_pass();
    act_q.delete();
    @(posedge clk); #1 frame_tick = 1;
    @(posedge clk); #1 frame_tick = 0;
    n = 0; got = 0; mid_done = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      cfg_we = 0;
      frame_tick = 0;
      if (frame_done) begin
        got = 1;
        break;
      end
      if (mid_at >= 0 && !mid_done && act_q.size() >= mid_at) begin
        drive_cfg(0, mid_rec);
        mid_done = 1;
      end
      if (extra_tick && n == 5) frame_tick = 1;
    end
    chk({tag, "_done"}, 32'(got), 1);
    if (mid_done) mt[0] = mid_rec;
    if (timed) chk({tag, "_cycles"}, n, exp_n);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_count"}, act_q.size(), exp_q.size());
    nq = act_q.size() < exp_q.size() ? act_q.size() : exp_q.size();
    for (int i = 0; i < nq; i++)
      chk({tag, "_pix"}, 32'(act_q[i]), 32'(exp_q[i]));
    repeat (6) @(negedge clk);
    chk({tag, "_idle"}, {31'(act_q.size()), busy}, {31'(nq), 1'b0});
  endtask

  initial begin
    mrec_t none;
    none = mk(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) mt[i] = none;
    frame_tick = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0; frame_tick = 0;
    @(negedge clk);
    chk("rst_we", 32'(pif.pix_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_pix", {pif.pix_x, pif.pix_y, pif.pix_colour}, 0);

    cfg_write(0, mk(1, 10, 20, 3, 2));
    run_frame("basic", 1, -1, none, 0);

    cfg_write(1, mk(1, 155, 40, 3, 3));
    cfg_write(2, mk(1, 158, 60, 3, 3));
    cfg_write(3, mk(1, 5, 2, 1, 3));
    cfg_write(4, mk(1, 0, 117, 0, 0));
    run_frame("edge1", 1, -1, none, 0);
    run_frame("edge2", 1, -1, none, 0);

    rnd_ready = 1;
    for (int f = 0; f < 6; f++) begin
      if (f % 2 == 0)
        for (int i = 0; i < 8; i++)
          cfg_write(i, mk(1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 159)),
                          int'($urandom_range(0, 119)),
                          int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3))));
      run_frame("rand", 0, -1, none, 0);
    end

    cfg_write(0, mk(1, 30, 30, 0, 1));
    run_frame("mid_draw", 0, 20, mk(1, 50, 50, 2, 2), 1);
    run_frame("after_draw", 0, -1, none, 0);
    run_frame("mid_erase", 0, 3, mk(1, 70, 80, 1, 1), 0);
    run_frame("after_erase", 0, -1, none, 0);

    rnd_ready = 0;
    cfg_write(0, mk(1, 40, 40, 3, 1));
    act_q.delete();
    @(posedge clk); #1 frame_tick = 1;
    @(posedge clk); #1 frame_tick = 0;
    for (int n = 0; n < 200 && act_q.size() < 3; n++) @(negedge clk);
    chk("abort_started", 32'(act_q.size() >= 3), 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort_we", 32'(pif.pix_we), 0);
    chk("abort_busy", 32'(busy), 0);
    reset = 0;
    for (int i = 0; i < 8; i++) mt[i] = none;
    run_frame("cleared", 1, -1, none, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
